// File: rtl/risc_pkg.sv
// Shared definitions for the load/store unit: opcodes, funct3 encodings and FSM states.
package risc_pkg;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/risc_lsu_align.sv
// Combinational lane steering: store byte enables/replication, load extraction and
// size/alignment legality checks.
module risc_lsu_align
  import risc_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] shifted;

  assign shifted = mem_rdata >> {offset, 3'b000};

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = store_data;
    illegal   = 1'b0;
    misalign  = 1'b0;
    load_data = mem_rdata;

    if (is_store) begin
      unique case (funct3)
        F3_B: begin
          mem_be    = 4'b0001 << offset;
          mem_wdata = {4{store_data[7:0]}};
        end
        F3_H: begin
          mem_be    = 4'b0011 << offset;
          mem_wdata = {2{store_data[15:0]}};
        end
        F3_W:    mem_be  = 4'b1111;
        default: illegal = 1'b1;
      endcase
    end else begin
      unique case (funct3)
        F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
        F3_BU:   load_data = {24'h0, shifted[7:0]};
        F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
        F3_HU:   load_data = {16'h0, shifted[15:0]};
        F3_W:    load_data = mem_rdata;
        default: illegal   = 1'b1;
      endcase
    end

    if (!illegal) begin
      if ((funct3 == F3_H) || (funct3 == F3_HU)) misalign = offset[0];
      else if (funct3 == F3_W)                   misalign = (offset != 2'b00);
    end
  end

endmodule

// File: rtl/risc_lsu.sv
// Load/store unit: one data-memory transaction per accepted LOAD/STORE, with a bus
// timeout and a one-cycle completion pulse toward writeback.
module risc_lsu
  import risc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        done_o,
  output logic        rf_we_o,
  output logic [4:0]  rd_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic        bus_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  lsu_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;
  logic        mis_q, mis_d, ill_q, ill_d, berr_q, berr_d;

  logic [6:0]  opcode;
  logic        is_ls, idle;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic        al_store;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_mis, al_ill;
  logic        unused_instr;

  assign opcode       = instruction[6:0];
  assign is_ls        = (opcode == LOAD) || (opcode == STORE);
  assign idle         = (state_q == IDLE);
  assign unused_instr = ^instruction[31:15];

  // The aligner sees the incoming instruction while idle and the latched one during access.
  assign al_f3    = idle ? instruction[14:12] : funct3_q;
  assign al_off   = idle ? addr[1:0] : off_q;
  assign al_store = idle ? (opcode == STORE) : we_q;

  risc_lsu_align u_align (
    .funct3     (al_f3),
    .offset     (al_off),
    .is_store   (al_store),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .mem_be     (al_be),
    .mem_wdata  (al_wdata),
    .load_data  (al_load),
    .misalign   (al_mis),
    .illegal    (al_ill)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    load_d   = load_q;
    mis_d    = mis_q;
    ill_d    = ill_q;
    berr_d   = berr_q;

    unique case (state_q)
      IDLE: begin
        if (valid_i && is_ls) begin
          funct3_d = instruction[14:12];
          rd_d     = instruction[11:7];
          off_d    = addr[1:0];
          addr_d   = {addr[31:2], 2'b00};
          be_d     = al_be;
          wdata_d  = al_wdata;
          we_d     = (opcode == STORE);
          mis_d    = al_mis;
          ill_d    = al_ill;
          berr_d   = 1'b0;
          cnt_d    = '0;
          state_d  = (al_mis || al_ill) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CntW'(1);
        if (mem_ready) begin
          load_d  = al_load;
          state_d = DONE;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          berr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      rd_q     <= 5'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      load_q   <= 32'h0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      load_q   <= load_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
      berr_q   <= berr_d;
    end
  end

  // Status outputs decode from state so an async reset clears them at once.
  assign ready_o     = idle;
  assign mem_req     = (state_q == ACCESS);
  assign done_o      = (state_q == DONE);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign rd_o        = rd_q;
  assign load_data_o = load_q;
  assign misalign_o  = done_o & mis_q;
  assign illegal_o   = done_o & ill_q;
  assign bus_err_o   = done_o & berr_q;
  assign rf_we_o     = done_o & ~we_q & ~(mis_q | ill_q | berr_q);

endmodule

// File: tb/tb_risc_lsu.sv
// Directed bench for risc_lsu: loads, stores, misalignment, illegal funct3, timeout, reset.
module tb_risc_lsu;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] instruction = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        done_o, rf_we_o;
  logic [4:0]  rd_o;
  logic [31:0] load_data_o;
  logic        misalign_o, illegal_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  // Snapshots taken by xact()
  int          lat, req_cycles;
  logic [31:0] s_addr, s_wdata, s_load;
  logic [3:0]  s_be;
  logic        s_we, s_mis, s_ill, s_berr, s_rfwe;
  logic [4:0]  s_rd;

  always #5 clk = ~clk;

  risc_lsu #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .instruction (instruction),
    .addr        (addr),
    .store_data  (store_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .done_o      (done_o),
    .rf_we_o     (rf_we_o),
    .rd_o        (rd_o),
    .load_data_o (load_data_o),
    .misalign_o  (misalign_o),
    .illegal_o   (illegal_o),
    .bus_err_o   (bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction; ready_at is the 1-based ACCESS cycle that sees mem_ready (0 = never).
  task automatic xact(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                      input int ready_at);
    lat = 0;
    req_cycles = 0;
    s_addr = 'x; s_be = 'x; s_wdata = 'x; s_we = 1'bx;
    instruction = {17'h0, f3, rd, op};
    addr        = a;
    store_data  = sd;
    valid_i     = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (done_o) begin
        lat    = k;
        s_mis  = misalign_o;
        s_ill  = illegal_o;
        s_berr = bus_err_o;
        s_rfwe = rf_we_o;
        s_rd   = rd_o;
        s_load = load_data_o;
        mem_ready = 1'b0;
        break;
      end
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          s_addr = mem_addr; s_be = mem_be; s_wdata = mem_wdata; s_we = mem_we;
        end
        mem_ready = (req_cycles == ready_at);
        mem_rdata = rdata;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_outs", {mem_req, mem_we, done_o, rf_we_o, misalign_o, illegal_o, bus_err_o},
          32'd0);
    check("rst_data", mem_addr | mem_wdata | load_data_o | 32'(mem_be) | 32'(rd_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LW aligned, ready in first access cycle
    xact(OP_LD, 3'b010, 5'd7, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_req", 32'(req_cycles), 32'd1);
    check("lw_addr", s_addr, 32'h100);
    check("lw_be", 32'(s_be), 32'hF);
    check("lw_we", 32'(s_we), 32'd0);
    check("lw_data", s_load, 32'hDEADBEEF);
    check("lw_rfwe", 32'(s_rfwe), 32'd1);
    check("lw_rd", 32'(s_rd), 32'd7);
    check("lw_after", {done_o, rf_we_o, ready_o}, 32'b001);

    xact(OP_LD, 3'b000, 5'd1, 32'h103, 32'h0, 32'h80FF0000, 1);
    check("lb_data", s_load, 32'hFFFFFF80);
    check("lb_addr", s_addr, 32'h100);
    xact(OP_LD, 3'b100, 5'd2, 32'h103, 32'h0, 32'h80FF0000, 1);
    check("lbu_data", s_load, 32'h00000080);
    xact(OP_LD, 3'b001, 5'd3, 32'h102, 32'h0, 32'h80FF0000, 1);
    check("lh_data", s_load, 32'hFFFF80FF);
    xact(OP_LD, 3'b101, 5'd4, 32'h102, 32'h0, 32'h80FF0000, 3);
    check("lhu_data", s_load, 32'h000080FF);
    check("lhu_lat", 32'(lat), 32'd4);

    xact(OP_ST, 3'b001, 5'd5, 32'h202, 32'h1234ABCD, 32'h0, 1);
    check("sh_we", 32'(s_we), 32'd1);
    check("sh_be", 32'(s_be), 32'hC);
    check("sh_wdata", s_wdata, 32'hABCDABCD);
    check("sh_addr", s_addr, 32'h200);
    check("sh_rfwe", 32'(s_rfwe), 32'd0);
    check("sh_lat", 32'(lat), 32'd2);

    xact(OP_ST, 3'b000, 5'd0, 32'h301, 32'h0000005A, 32'h0, 1);
    check("sb_be", 32'(s_be), 32'h2);
    check("sb_wdata", s_wdata, 32'h5A5A5A5A);
    xact(OP_ST, 3'b010, 5'd0, 32'h304, 32'hCAFEF00D, 32'h0, 1);
    check("sw_be", 32'(s_be), 32'hF);
    check("sw_wdata", s_wdata, 32'hCAFEF00D);

    // Misaligned: no bus access, done one cycle after accept
    xact(OP_LD, 3'b010, 5'd6, 32'h101, 32'h0, 32'h0, 1);
    check("lw_mis_flag", 32'(s_mis), 32'd1);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_req", 32'(req_cycles), 32'd0);
    check("lw_mis_rfwe", 32'(s_rfwe), 32'd0);
    xact(OP_ST, 3'b001, 5'd6, 32'h203, 32'h0, 32'h0, 1);
    check("sh_mis_flag", 32'(s_mis), 32'd1);
    check("sh_mis_lat", 32'(lat), 32'd1);
    check("sh_mis_req", 32'(req_cycles), 32'd0);

    // Illegal funct3
    xact(OP_LD, 3'b011, 5'd8, 32'h100, 32'h0, 32'h0, 1);
    check("ill_flag", 32'(s_ill), 32'd1);
    check("ill_req", 32'(req_cycles), 32'd0);
    check("ill_rfwe", 32'(s_rfwe), 32'd0);
    xact(OP_ST, 3'b100, 5'd8, 32'h100, 32'h0, 32'h0, 1);
    check("st_ill_flag", 32'(s_ill), 32'd1);

    // Timeout, then ready arriving exactly on the last allowed cycle
    xact(OP_LD, 3'b010, 5'd9, 32'h400, 32'h0, 32'h11111111, 0);
    check("to_req", 32'(req_cycles), 32'd16);
    check("to_lat", 32'(lat), 32'd17);
    check("to_berr", 32'(s_berr), 32'd1);
    check("to_rfwe", 32'(s_rfwe), 32'd0);
    xact(OP_LD, 3'b010, 5'd9, 32'h400, 32'h0, 32'h22222222, 16);
    check("to16_berr", 32'(s_berr), 32'd0);
    check("to16_rfwe", 32'(s_rfwe), 32'd1);
    check("to16_data", s_load, 32'h22222222);
    check("to16_lat", 32'(lat), 32'd17);

    // Non-memory opcode is ignored
    instruction = {17'h0, 3'b000, 5'd1, OP_R};
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    check("nonls_idle", {ready_o, mem_req, done_o}, 32'b100);

    // Reset during access drops the request asynchronously and yields no done
    instruction = {17'h0, 3'b010, 5'd3, OP_LD};
    addr = 32'h500;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(posedge clk);
    #1 check("rst_mid_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_ready", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done_o) seen++;
      end
      check("rst_no_done", 32'(seen), 32'd0);
    end
    check("rst_post_ready", 32'(ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_lsu.md
Name: risc_lsu

Overview:
- Load/store unit. Consumes the effective address computed by the ALU for LOAD/STORE opcodes, runs one data-memory transaction per instruction over a req/ready bus, and returns the sign- or zero-extended load result to the writeback stage.
- Sits after the ALU in the pipeline.
- Accepts one instruction at a time; the pipeline stalls while `ready_o` is low.

Parameters:
- `TIMEOUT`, 16: maximum cycles `mem_req` stays high without `mem_ready` before a bus error is reported. Legal range is ≥2.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `valid_i` in 1: an instruction is presented.
- `ready_o` out 1: unit is idle and can accept.
- `instruction` in 32: instruction word; fields used are opcode [6:0], funct3 [14:12] and rd [11:7].
- `addr` in 32: effective address (ALU result).
- `store_data` in 32: rs2 value.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned address.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: memory completes the access this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready` is high.
- `done_o` out 1: one-cycle completion pulse.
- `rf_we_o` out 1: write `load_data_o` to `rd_o`; valid with `done_o`.
- `rd_o` out 5: destination register.
- `load_data_o` out 32: extended load result.
- `misalign_o` out 1: misaligned access; valid with `done_o`.
- `illegal_o` out 1: unsupported funct3; valid with `done_o`.
- `bus_err_o` out 1: timeout; valid with `done_o`.

Behaviour:
- **Reset.** All outputs are 0 except `ready_o`, which is 1. State is IDLE and the counter is 0. Reset asserted mid-access drops `mem_req` immediately (asynchronously) and produces no `done_o`.
- **States.** IDLE, ACCESS, DONE.
- **IDLE.**
  - `ready_o` = 1.
  - Accept when `valid_i` = 1 and opcode is LOAD (0000011) or STORE (0100011). Other opcodes with `valid_i` are ignored and the state stays IDLE.
  - On accept, latch funct3, rd, `addr[1:0]`, `mem_addr = {addr[31:2],2'b00}`, `mem_be`, `mem_wdata` and `mem_we`.
  - Legal LOAD funct3 values: 000, 001, 010, 100, 101. Legal STORE funct3 values: 000, 001, 010. Any other value sets `illegal_o`.
  - Misaligned cases set `misalign_o`:
    - halfword (001/101) with `addr[0]` = 1;
    - word (010) with `addr[1:0]` ≠ 00.
  - If `illegal_o` or `misalign_o` is set, go to DONE with no memory request. Otherwise go to ACCESS.
- **ACCESS.**
  - `mem_req` = 1. Address, byte enables, write data and write enable are held stable.
  - The counter increments each cycle.
  - If `mem_ready` = 1: capture the extracted load data and go to DONE.
  - Else if counter = `TIMEOUT`-1: set `bus_err_o` and go to DONE.
  - If `mem_ready` arrives on the timeout cycle, `mem_ready` wins and no error is reported.
- **DONE.**
  - `done_o` = 1 for exactly one cycle, then return to IDLE.
  - `rf_we_o` = LOAD and no error flag set.
  - Flags and `rf_we_o` are 0 outside DONE. `load_data_o` holds its last value.
- **Latency.**
  - Accept in cycle N, `mem_req` high in N+1; with `mem_ready` in N+1, `done_o` in N+2.
  - Error without access: `done_o` in N+1.
  - Timeout: `done_o` in N+1+`TIMEOUT`.
- **Byte enables and write data.**
  - SB: `mem_be = 4'b0001 << addr[1:0]`, `mem_wdata = {4{store_data[7:0]}}`.
  - SH: `mem_be = 4'b0011 << addr[1:0]`, `mem_wdata = {2{store_data[15:0]}}`.
  - SW: `mem_be = 4'b1111`, `mem_wdata = store_data`.
  - Loads drive `mem_be = 4'b1111`.
- **Load extraction.** Let `sh = mem_rdata >> (8*addr[1:0])`.
  - LB: sign-extend `sh[7:0]`.
  - LBU: zero-extend `sh[7:0]`.
  - LH: sign-extend `sh[15:0]`.
  - LHU: zero-extend `sh[15:0]`.
  - LW: `mem_rdata`.
- **Input stability.** `valid_i` while not ready is not captured; the pipeline holds the instruction until `ready_o` is high.

Decomposition:
- **Shared package `risc_pkg`:**
  - opcode constants LOAD/STORE;
  - funct3 constants F3_B/H/W/BU/HU;
  - `lsu_state_t` enum {IDLE, ACCESS, DONE}.
- **Sub-module `risc_lsu_align`:** purely combinational.
  - Inputs: funct3, `addr[1:0]`, `store_data`, `mem_rdata`.
  - Outputs: `mem_be`, `mem_wdata`, `load_data`, misalign, illegal.
- **Top:** FSM, timeout counter and registers.

Test Plan:
- LW `addr` 0x100, `mem_rdata` 0xDEADBEEF, `mem_ready` in the first ACCESS cycle → `mem_addr` 0x100, `mem_be` 1111, `done_o` at N+2, `load_data_o` 0xDEADBEEF, `rf_we_o` = 1.
- LB / LBU `addr` 0x103, `mem_rdata` 0x80FF_0000 → `load_data_o` 0xFFFFFF80 / 0x00000080.
- SH `addr` 0x202, `store_data` 0x1234ABCD → `mem_we` = 1, `mem_be` 1100, `mem_wdata` 0xABCDABCD, `rf_we_o` = 0.
- LW `addr` 0x101 → `misalign_o` = 1 at N+1, `mem_req` never asserted, `rf_we_o` = 0. Same result for SH at 0x203.
- LW with `mem_ready` held 0 and `TIMEOUT`=16 → `mem_req` high 16 cycles, then `bus_err_o` with `done_o`. Repeat with `mem_ready` = 1 on cycle 16 → no error.
- `rst_n` pulled low during ACCESS → `mem_req` = 0 immediately, no `done_o`, `ready_o` = 1 after release. LOAD funct3 011 → `illegal_o` = 1, no access.
